bcd_inv_sched: RTL and testbench

Scheduler that time-shares one registered BCD digit-inverter (the 1-cycle-latency 9's-complement unit decoder) across all NDIG digits of a time/count word. On a start request it snapshots the word, issues one digit per cycle to the shared decoder, collects the pipelined results, and presents the fully inverted word atomically with a one-cycle done pulse. It sits between the timer/counter register bank and the display/countdown path, replacing one decoder instance per digit.

---
 rtl/bcd_inv_pkg.sv | 22 ++
 rtl/bcd_digit_sel.sv | 31 +++
 rtl/bcd_inv_sched.sv | 125 ++++++++++++
 tb/tb_bcd_inv_sched.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_inv_pkg.sv
// ============================================================================
// Module   : bcd_inv_pkg
// Brief    : Shared types and constants for the BCD digit-inverter scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bcd_inv_pkg;

  localparam int DIGIT_W  = 4;
  localparam int NDIG_DEF = 6;
  localparam int BCD_MAX  = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_sel.sv
// ============================================================================
// Module   : bcd_digit_sel
// Brief    : Selects one BCD nibble of a packed word by digit index.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_digit_sel
  import bcd_inv_pkg::*;
#(
  parameter int NDIG  = NDIG_DEF,
  parameter int IDX_W = 3
) (
  input  logic [DIGIT_W*NDIG-1:0] i_word,
  input  logic [IDX_W-1:0]        i_idx,
  output logic [DIGIT_W-1:0]      o_digit
);

  // Out-of-range indices select zero so the decoder sees a benign code.
  always_comb begin
    o_digit = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (i_idx == IDX_W'(k)) begin
        o_digit = i_word[k*DIGIT_W +: DIGIT_W];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_inv_sched.sv
// ============================================================================
// Module   : bcd_inv_sched
// Brief    : Time-shares one registered 9's-complement BCD decoder across all
//            digits of a word and presents the inverted word atomically.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_inv_sched
  import bcd_inv_pkg::*;
#(
  parameter int NDIG = NDIG_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DIGIT_W*NDIG-1:0] digits_i,
  output logic [DIGIT_W-1:0]      dec_code_o,
  input  logic [DIGIT_W-1:0]      dec_data_i,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*NDIG-1:0] digits_o,
  output logic                    err_o
);

  localparam int                 c_IDX_W  = $clog2(NDIG);
  localparam int                 c_WORD_W = DIGIT_W * NDIG;
  localparam int                 c_WORK_W = DIGIT_W * (NDIG - 1);
  localparam logic [c_IDX_W-1:0] c_LAST   = c_IDX_W'(NDIG - 1);

  state_t                r_state;
  logic [c_IDX_W-1:0]    r_idx;
  logic [c_WORD_W-1:0]   r_snap;
  logic [c_WORK_W-1:0]   r_work;
  logic                  r_err;
  logic [DIGIT_W-1:0]    w_sel;
  logic                  w_err;

  bcd_digit_sel #(
    .NDIG  (NDIG),
    .IDX_W (c_IDX_W)
  ) u_digit_sel (
    .i_word  (r_snap),
    .i_idx   (r_idx),
    .o_digit (w_sel)
  );

  assign dec_code_o = (r_state == ST_ISSUE) ? w_sel : '0;

  // Invalid-digit flag is computed on the live input so it lands with the snapshot.
  always_comb begin
    w_err = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (digits_i[k*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX)) begin
        w_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_snap   <= '0;
      r_work   <= '0;
      r_err    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      digits_o <= '0;
      err_o    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_snap  <= digits_i;
            r_idx   <= '0;
            r_err   <= w_err;
            busy    <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          r_idx <= r_idx + c_IDX_W'(1);
          // Decoder output lags the issued code by one cycle: slot idx-1.
          for (int k = 0; k < NDIG - 1; k++) begin
            if (r_idx == c_IDX_W'(k + 1)) begin
              r_work[k*DIGIT_W +: DIGIT_W] <= dec_data_i;
            end
          end
          if (r_idx == c_LAST) begin
            r_state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          digits_o <= {dec_data_i, r_work};
          err_o    <= r_err;
          done     <= 1'b1;
          r_idx    <= '0;
          // Accepting start here keeps throughput at one run per NDIG+1 cycles.
          if (start) begin
            r_snap  <= digits_i;
            r_err   <= w_err;
            busy    <= 1'b1;
            r_state <= ST_ISSUE;
          end else begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          busy    <= 1'b0;
          r_idx   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_inv_sched.sv
// ============================================================================
// Module   : tb_bcd_inv_sched
// Brief    : Directed self-checking bench for bcd_inv_sched with a 1-cycle
//            behavioural 9's-complement decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_inv_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] digits_i;
  logic [3:0]  dec_code_o;
  logic [3:0]  dec_data_i = 4'd0;
  logic        busy;
  logic        done;
  logic [23:0] digits_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  bcd_inv_sched #(.NDIG(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .digits_i   (digits_i),
    .dec_code_o (dec_code_o),
    .dec_data_i (dec_data_i),
    .busy       (busy),
    .done       (done),
    .digits_o   (digits_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  // Shared decoder: 0..8 -> 9-d, 9 and 10..15 -> 0, one cycle latency.
  always_ff @(posedge clk) begin
    dec_data_i <= (dec_code_o <= 4'd9) ? (4'd9 - dec_code_o) : 4'd0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run and follows it to done, checking codes, latency, busy length and result.
  task automatic do_run(input logic [23:0] word, input logic [23:0] exp_word, input logic exp_err);
    int n;
    int busy_cnt;
    logic seen;
    digits_i = word;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    n        = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (n < 20 && !seen) begin
      if (busy) busy_cnt++;
      if (n < 6) check("dec_code", 32'(dec_code_o), 32'(word[4*n +: 4]));
      if (n == 6) check("dec_code_drain", 32'(dec_code_o), 32'd0);
      if (done) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    check("done_latency", 32'(n), 32'd7);
    check("busy_cycles", 32'(busy_cnt), 32'd7);
    check("busy_at_done", 32'(busy), 32'd0);
    check("digits_o", 32'(digits_o), 32'(exp_word));
    check("err_o", 32'(err_o), 32'(exp_err));
    tick();
    check("done_pulse_width", 32'(done), 32'd0);
    check("digits_o_held", 32'(digits_o), 32'(exp_word));
  endtask

  initial begin
    int n;
    int done_cnt;
    int first_t;
    int second_t;
    int busy_cnt;

    reset    = 1'b1;
    start    = 1'b0;
    digits_i = 24'h0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_digits_o", 32'(digits_o), 32'd0);
    check("rst_err_o", 32'(err_o), 32'd0);
    check("rst_dec_code", 32'(dec_code_o), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Basic and invalid-digit runs
    do_run(24'h123456, 24'h876543, 1'b0);
    do_run(24'h09A800, 24'h900199, 1'b1);

    // Start re-asserted and input changed while busy
    digits_i = 24'h111111;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
    start    = 1'b1;
    digits_i = 24'h000000;
    tick();
    start    = 1'b0;
    n        = 2;
    done_cnt = 0;
    first_t  = -1;
    while (n < 20) begin
      if (done) begin
        done_cnt++;
        if (first_t < 0) begin
          first_t = n;
          check("ignore_digits_o", 32'(digits_o), 32'h888888);
          check("ignore_err_o", 32'(err_o), 32'd0);
        end
      end
      tick();
      n++;
    end
    check("ignore_latency", 32'(first_t), 32'd7);
    check("ignore_done_count", 32'(done_cnt), 32'd1);

    // Back-to-back with start held high
    digits_i = 24'h000987;
    start    = 1'b1;
    tick();
    digits_i = 24'h555555;
    n        = 0;
    done_cnt = 0;
    first_t  = -1;
    second_t = -1;
    busy_cnt = 0;
    while (n < 24) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (first_t < 0) begin
          first_t = n;
          start   = 1'b0;
          check("b2b_first_digits_o", 32'(digits_o), 32'h999012);
        end else begin
          second_t = n;
          check("b2b_second_digits_o", 32'(digits_o), 32'h444444);
        end
      end
      tick();
      n++;
    end
    start = 1'b0;
    check("b2b_first_time", 32'(first_t), 32'd7);
    check("b2b_second_time", 32'(second_t), 32'd14);
    check("b2b_done_count", 32'(done_cnt), 32'd2);
    check("b2b_busy_cycles", 32'(busy_cnt), 32'd14);

    // Reset in the third ISSUE cycle
    digits_i = 24'h123456;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_digits_o", 32'(digits_o), 32'd0);
    check("midrst_err_o", 32'(err_o), 32'd0);
    check("midrst_dec_code", 32'(dec_code_o), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    do_run(24'h123456, 24'h876543, 1'b0);

    // Reset and start together: reset wins
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rst_vs_start_busy", 32'(busy), 32'd0);
    check("rst_vs_start_digits_o", 32'(digits_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
